pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_if.sv | 30 +++
 rtl/pixel_writer.sv | 164 ++++++++++++++++
 tb/tb_pixel_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_writer_if.sv
// Bundle of signals between the pixel writer, its coordinate generator and the SRAM port.
// The pixel writer uses the slave modport; the generator/SRAM side uses the master modport.
interface pixel_writer_if;
  logic        start;
  logic [9:0]  i_X_pos;
  logic [9:0]  i_Y_pos;
  logic        i_done;
  logic [15:0] i_color;
  logic        o_renew;
  logic        o_end_frame;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_sram_we_n;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_error;
  logic [19:0] o_pix_cnt;

  modport master (
    output start, i_X_pos, i_Y_pos, i_done, i_color,
    input  o_renew, o_end_frame, o_sram_addr, o_sram_dq, o_sram_we_n,
    input  o_busy, o_frame_done, o_error, o_pix_cnt
  );

  modport slave (
    input  start, i_X_pos, i_Y_pos, i_done, i_color,
    output o_renew, o_end_frame, o_sram_addr, o_sram_dq, o_sram_we_n,
    output o_busy, o_frame_done, o_error, o_pix_cnt
  );
endinterface

// File: rtl/pixel_writer.sv
// Walks a coordinate generator through one frame, writing each new in-range pixel to SRAM
// as Y*H_RES+X; skips duplicates and off-screen points and aborts after MAX_ITER samples.
module pixel_writer #(
  parameter int H_RES         = 800,
  parameter int X_MAX         = 799,
  parameter int Y_MAX         = 599,
  parameter int WR_CYCLES     = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_ITER      = 4095
) (
  input  logic           clk,
  input  logic           rst,
  pixel_writer_if.slave  bus
);
  localparam int               ITER_W      = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam int               CNT_W       = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(WR_CYCLES - 1);
  localparam logic [19:0]      H_RES_W     = 20'(H_RES);

  typedef enum logic [2:0] {IDLE, INIT, SETTLE, SAMPLE, WRITE, ADV, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ITER_W-1:0] iter_reg;
  logic [9:0]        x_reg, y_reg, last_x_reg, last_y_reg;
  logic              last_valid_reg, done_reg, abort_reg;
  logic              renew_reg, end_frame_reg, we_n_reg, busy_reg, frame_done_reg, error_reg;
  logic [19:0]       addr_reg, pix_cnt_reg;
  logic [15:0]       dq_reg;

  logic [ITER_W-1:0] iter_next;
  logic              in_range, is_new, limit_hit;
  logic [19:0]       addr_calc;

  assign iter_next = iter_reg + 1'b1;
  assign limit_hit = (iter_next == ITER_LIMIT);
  assign in_range  = (bus.i_X_pos <= 10'(X_MAX)) && (bus.i_Y_pos <= 10'(Y_MAX));
  assign is_new    = !last_valid_reg || (bus.i_X_pos != last_x_reg) || (bus.i_Y_pos != last_y_reg);
  // Full 20-bit product so the bottom-right corner address is not truncated.
  assign addr_calc = ({10'd0, bus.i_Y_pos} * H_RES_W) + {10'd0, bus.i_X_pos};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      iter_reg       <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      last_x_reg     <= '0;
      last_y_reg     <= '0;
      last_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      abort_reg      <= 1'b0;
      renew_reg      <= 1'b0;
      end_frame_reg  <= 1'b0;
      we_n_reg       <= 1'b1;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      error_reg      <= 1'b0;
      addr_reg       <= '0;
      dq_reg         <= '0;
      pix_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg      <= INIT;
            end_frame_reg  <= 1'b1;
            busy_reg       <= 1'b1;
            pix_cnt_reg    <= '0;
            iter_reg       <= '0;
            error_reg      <= 1'b0;
            last_valid_reg <= 1'b0;
            abort_reg      <= 1'b0;
          end
        end
        INIT: begin
          end_frame_reg <= 1'b0;
          cnt_reg       <= '0;
          state_reg     <= SETTLE;
        end
        SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= SAMPLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SAMPLE: begin
          x_reg     <= bus.i_X_pos;
          y_reg     <= bus.i_Y_pos;
          done_reg  <= bus.i_done;
          dq_reg    <= bus.i_color;
          iter_reg  <= iter_next;
          abort_reg <= limit_hit && !bus.i_done;
          if (in_range && is_new) begin
            addr_reg  <= addr_calc;
            we_n_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= WRITE;
          end else if (bus.i_done) begin
            frame_done_reg <= 1'b1;
            state_reg      <= DONE;
          end else if (limit_hit) begin
            frame_done_reg <= 1'b1;
            error_reg      <= 1'b1;
            state_reg      <= DONE;
          end else begin
            renew_reg <= 1'b1;
            state_reg <= ADV;
          end
        end
        WRITE: begin
          if (cnt_reg == WR_LAST) begin
            we_n_reg       <= 1'b1;
            cnt_reg        <= '0;
            pix_cnt_reg    <= pix_cnt_reg + 1'b1;
            last_x_reg     <= x_reg;
            last_y_reg     <= y_reg;
            last_valid_reg <= 1'b1;
            // A pending abort is honoured only once the write has completed.
            if (done_reg) begin
              frame_done_reg <= 1'b1;
              state_reg      <= DONE;
            end else if (abort_reg) begin
              frame_done_reg <= 1'b1;
              error_reg      <= 1'b1;
              state_reg      <= DONE;
            end else begin
              renew_reg <= 1'b1;
              state_reg <= ADV;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ADV: begin
          renew_reg <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= SETTLE;
        end
        DONE: begin
          frame_done_reg <= 1'b0;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_renew      = renew_reg;
  assign bus.o_end_frame  = end_frame_reg;
  assign bus.o_sram_addr  = addr_reg;
  assign bus.o_sram_dq    = dq_reg;
  assign bus.o_sram_we_n  = we_n_reg;
  assign bus.o_busy       = busy_reg;
  assign bus.o_frame_done = frame_done_reg;
  assign bus.o_error      = error_reg;
  assign bus.o_pix_cnt    = pix_cnt_reg;
endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: a scripted coordinate generator feeds directed and random frames,
// and a frame-level model predicts writes, renew/done timing, pixel count and error.
module tb_pixel_writer;
  localparam int H = 800, XM = 799, YM = 599, WR = 2, ST = 2, MAXI = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_writer_if bus ();
  pixel_writer #(.MAX_ITER(MAXI)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Generator: point list walked by o_renew, rewound by o_end_frame, last point held.
  int          gx[8], gy[8];
  bit          gd[8];
  logic [15:0] gc[8];
  int          glen = 1;
  int          gidx = 0;

  always @(posedge clk) begin
    if (bus.o_end_frame) gidx <= 0;
    else if (bus.o_renew) gidx <= gidx + 1;
  end

  always_comb begin
    int k;
    k = (gidx < glen) ? gidx : glen - 1;
    bus.i_X_pos = 10'(gx[k]);
    bus.i_Y_pos = 10'(gy[k]);
    bus.i_done  = gd[k];
    bus.i_color = gc[k];
  end

  // Monitor
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          fall_t[$], w_len[$], renew_t[$], ef_t[$], fd_t[$];
  logic [19:0] w_addr[$];
  logic [15:0] w_dq[$];
  int          cur_len = 0;
  bit          prev_we = 1'b1;
  bit          overlap = 1'b0, unstable = 1'b0, fd_err = 1'b0;
  logic [19:0] fd_pc = '0;

  always @(negedge clk) begin
    if (!bus.o_sram_we_n) begin
      if (prev_we) begin
        fall_t.push_back(cyc);
        w_addr.push_back(bus.o_sram_addr);
        w_dq.push_back(bus.o_sram_dq);
        cur_len = 1;
      end else begin
        cur_len++;
        if (bus.o_sram_addr !== w_addr[$] || bus.o_sram_dq !== w_dq[$]) unstable = 1'b1;
      end
    end else if (!prev_we) begin
      w_len.push_back(cur_len);
    end
    prev_we = bus.o_sram_we_n;
    if (bus.o_renew) renew_t.push_back(cyc);
    if (bus.o_end_frame) ef_t.push_back(cyc);
    if (bus.o_frame_done) begin
      fd_t.push_back(cyc);
      fd_pc  = bus.o_pix_cnt;
      fd_err = bus.o_error;
    end
    if ((int'(bus.o_renew) + int'(bus.o_end_frame) + int'(bus.o_frame_done)) > 1) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    fall_t.delete(); w_len.delete(); renew_t.delete(); ef_t.delete(); fd_t.delete();
    w_addr.delete(); w_dq.delete();
    overlap = 1'b0; unstable = 1'b0;
  endtask

  task automatic set_pt(input int i, input int x, input int y, input bit d, input logic [15:0] c);
    gx[i] = x; gy[i] = y; gd[i] = d; gc[i] = c;
  endtask

  // Runs one frame over the current generator list and compares against the model.
  // stress=1 also pulses start mid-frame and during the DONE cycle; both must be ignored.
  task automatic run_frame(input string name, input bit stress);
    int s, t, n, samples, lx, ly, done_t;
    bit lv, stop, err;
    int e_addr[$], e_dq[$], e_t[$], e_rn[$];
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1;
    s = cyc;
    // Model: cycle of the first sample, then per-sample write/skip/advance rules.
    t = s + 1 + 1 + ST;
    lv = 0; lx = 0; ly = 0; samples = 0; stop = 0; err = 0;
    for (int i = 0; !stop; i++) begin
      int k;
      k = (i < glen) ? i : glen - 1;
      samples++;
      if (gx[k] <= XM && gy[k] <= YM && !(lv && gx[k] == lx && gy[k] == ly)) begin
        e_addr.push_back(gy[k] * H + gx[k]);
        e_dq.push_back(int'(gc[k]));
        e_t.push_back(t + 1);
        lv = 1; lx = gx[k]; ly = gy[k];
        t = t + 1 + WR;
      end else begin
        t = t + 1;
      end
      if (gd[k]) stop = 1;
      else if (samples == MAXI) begin stop = 1; err = 1; end
      else begin e_rn.push_back(t); t = t + 1 + ST; end
    end
    done_t = t;

    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #2;
    chk({name, " busy_after_start"}, 32'(bus.o_busy), 32'd1);
    chk({name, " error_cleared"}, 32'(bus.o_error), 32'd0);

    n = 0;
    while (n < 400) begin
      @(negedge clk); #2;
      n++;
      bus.start = stress && (cyc == s + 4 || cyc == done_t);
      if (fd_t.size() != 0) break;
    end
    chk({name, " frame_done_seen"}, 32'(fd_t.size()), 32'd1);
    if (fd_t.size() == 0) return;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #2;
    chk({name, " busy_after_done"}, 32'(bus.o_busy), 32'd0);

    chk({name, " end_frame_cnt"}, 32'(ef_t.size()), 32'd1);
    chk({name, " end_frame_t"}, 32'(ef_t[0] - s), 32'd1);
    chk({name, " done_t"}, 32'(fd_t[0] - s), 32'(done_t - s));
    chk({name, " pix_cnt"}, 32'(fd_pc), 32'(e_addr.size()));
    chk({name, " error"}, 32'(fd_err), 32'(err));
    chk({name, " writes"}, 32'(w_addr.size()), 32'(e_addr.size()));
    chk({name, " write_lens"}, 32'(w_len.size()), 32'(e_addr.size()));
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      chk($sformatf("%s addr%0d", name, i), 32'(w_addr[i]), 32'(e_addr[i]));
      chk($sformatf("%s dq%0d", name, i), 32'(w_dq[i]), 32'(e_dq[i]));
      chk($sformatf("%s fall%0d", name, i), 32'(fall_t[i] - s), 32'(e_t[i] - s));
      if (i < w_len.size()) chk($sformatf("%s len%0d", name, i), 32'(w_len[i]), 32'(WR));
    end
    chk({name, " renews"}, 32'(renew_t.size()), 32'(e_rn.size()));
    for (int i = 0; i < e_rn.size() && i < renew_t.size(); i++)
      chk($sformatf("%s renew%0d", name, i), 32'(renew_t[i] - s), 32'(e_rn[i] - s));
    chk({name, " overlap"}, 32'(overlap), 32'd0);
    chk({name, " stable"}, 32'(unstable), 32'd0);
    if (stress) begin
      repeat (3) @(negedge clk);
      #2;
      chk({name, " ignored_start"}, 32'(bus.o_busy), 32'd0);
    end
    $display("[TB] frame %s: %0d samples, %0d writes, %0d renews, error=%0d",
             name, samples, w_addr.size(), renew_t.size(), fd_err);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) set_pt(i, 0, 0, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    #2;
    chk("reset we_n", 32'(bus.o_sram_we_n), 32'd1);
    chk("reset busy", 32'(bus.o_busy), 32'd0);
    chk("reset addr", 32'(bus.o_sram_addr), 32'd0);
    chk("reset dq", 32'(bus.o_sram_dq), 32'd0);
    chk("reset pix_cnt", 32'(bus.o_pix_cnt), 32'd0);
    chk("reset pulses", 32'({bus.o_renew, bus.o_end_frame, bus.o_frame_done, bus.o_error}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    glen = 1; set_pt(0, 10, 5, 1'b1, 16'hF800);
    run_frame("single", 1'b0);
    chk("single addr4010", 32'(w_addr[0]), 32'd4010);

    glen = 3;
    set_pt(0, 0, 0, 1'b0, 16'h1111); set_pt(1, 1, 0, 1'b0, 16'h2222); set_pt(2, 2, 0, 1'b1, 16'h3333);
    run_frame("line3", 1'b0);
    if (renew_t.size() == 2) chk("line3 renew_gap", 32'(renew_t[1] - renew_t[0]), 32'd6);

    glen = 4;
    set_pt(0, 800, 0, 1'b0, 16'hAAAA); set_pt(1, 3, 3, 1'b0, 16'hBBBB);
    set_pt(2, 3, 3, 1'b0, 16'hCCCC); set_pt(3, 4, 3, 1'b1, 16'hDDDD);
    run_frame("skipdup", 1'b0);

    glen = 1; set_pt(0, 799, 599, 1'b1, 16'h07E0);
    run_frame("corner", 1'b1);
    chk("corner addr479999", 32'(w_addr[0]), 32'd479999);

    glen = 3;
    set_pt(0, 1, 1, 1'b0, 16'h0101); set_pt(1, 2, 2, 1'b0, 16'h0202); set_pt(2, 3, 3, 1'b0, 16'h0303);
    run_frame("timeout", 1'b0);
    repeat (5) @(negedge clk);
    #2;
    chk("timeout error_sticky", 32'(bus.o_error), 32'd1);

    // Reset during the first write cycle.
    glen = 1; set_pt(0, 7, 9, 1'b1, 16'h1234);
    clear_mon();
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int n = 0; n < 50 && bus.o_sram_we_n; n++) begin @(negedge clk); #2; end
    chk("rstmid we_low", 32'(bus.o_sram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid we_n_async", 32'(bus.o_sram_we_n), 32'd1);
    chk("rstmid busy", 32'(bus.o_busy), 32'd0);
    chk("rstmid pix_cnt", 32'(bus.o_pix_cnt), 32'd0);
    repeat (2) @(negedge clk);
    clear_mon();
    @(posedge clk); #1; rst = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("rstmid no_done", 32'(fd_t.size()), 32'd0);
    chk("rstmid idle", 32'(bus.o_busy), 32'd0);
    run_frame("after_rst", 1'b0);

    for (int f = 0; f < 10; f++) begin
      glen = $urandom_range(1, 5);
      for (int i = 0; i < glen; i++) begin
        int x, y;
        x = ($urandom_range(0, 7) == 0) ? $urandom_range(800, 1023) : $urandom_range(0, 799);
        y = ($urandom_range(0, 7) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 599);
        if (i > 0 && $urandom_range(0, 3) == 0) begin x = gx[i-1]; y = gy[i-1]; end
        set_pt(i, x, y, 1'b0, 16'($urandom));
      end
      gd[glen-1] = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", f), f[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
